iq_uart_framer: RTL

- Consumer of the PSK correlator dispatcher's output stream: `value[7:0]` plus a single-cycle `rdy` strobe, with I and Q bytes strictly alternating.
- Groups consecutive bytes into pairs (A, B) and wraps each pair in a fixed frame: sync byte, A, B, optional checksum.
- Serialises the frame on a UART 8N1 line so correlator output can be logged on a host.
- One pending-pair buffer absorbs a pair that arrives during transmission; further pairs are dropped and counted.

---
 rtl/iq_uart_framer_pkg.sv | 23 ++
 rtl/iq_uart_framer_tx_byte.sv | 108 ++++++++++
 rtl/iq_uart_framer.sv | 119 +++++++++++
 3 files changed

// File: rtl/iq_uart_framer_pkg.sv
// Shared types and frame constants for the I/Q UART framer.
// IQ_UART_FRAMER_CHECKSUM_EN selects the 4-byte frame with a trailing checksum.
package iq_uart_framer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

`ifdef IQ_UART_FRAMER_CHECKSUM_EN
    localparam int FRAME_LEN = 4;
`else
    localparam int FRAME_LEN = 3;
`endif

    // Index of the final byte of a frame (sync is index 0).
    localparam logic [1:0] LAST_IDX = 2'(FRAME_LEN - 1);

endpackage

// File: rtl/iq_uart_framer_tx_byte.sv
// UART 8N1 byte serialiser (module uart_tx_byte). A start accepted while idle or
// on the final stop-bit cycle (done=1) chains the next byte with no gap.
module uart_tx_byte
    import iq_uart_framer_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    tx_state_t        state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       bit_reg, bit_next;
    logic [7:0]       shift_reg, shift_next;
    logic             tx_reg, tx_next;
    logic             cnt_last;

    assign cnt_last = (cnt_reg == CNT_W'(CLKS_PER_BIT - 1));
    assign done     = (state_reg == ST_STOP) && cnt_last;
    assign tx       = tx_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            tx_reg    <= 1'b1;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            tx_reg    <= tx_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        tx_next    = tx_reg;
        case (state_reg)
            ST_IDLE: begin
                tx_next  = 1'b1;
                cnt_next = '0;
                if (start) begin
                    state_next = ST_START;
                    shift_next = data;
                    tx_next    = 1'b0;
                end
            end
            ST_START: begin
                if (cnt_last) begin
                    cnt_next   = '0;
                    bit_next   = '0;
                    state_next = ST_DATA;
                    tx_next    = shift_reg[0];
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt_last) begin
                    cnt_next = '0;
                    if (bit_reg == 3'd7) begin
                        state_next = ST_STOP;
                        tx_next    = 1'b1;
                    end else begin
                        bit_next   = bit_reg + 3'd1;
                        shift_next = {1'b0, shift_reg[7:1]};
                        tx_next    = shift_reg[1];
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (cnt_last) begin
                    cnt_next = '0;
                    if (start) begin
                        state_next = ST_START;
                        shift_next = data;
                        tx_next    = 1'b0;
                    end else begin
                        state_next = ST_IDLE;
                        tx_next    = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/iq_uart_framer.sv
// Pairs dispatcher bytes and sends each pair as a UART frame: sync, A, B [, checksum].
// Optional checksum byte enabled by IQ_UART_FRAMER_CHECKSUM_EN.
module iq_uart_framer
    import iq_uart_framer_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 104,
    parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE,
    parameter int         DROP_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        value,
    input  logic              rdy,
    output logic              tx,
    output logic              busy,
    output logic              pend,
    output logic [DROP_W-1:0] drop_cnt
);

    logic              slot_reg;      // 0 = next byte is A, 1 = next byte is B
    logic [7:0]        a_reg;
    logic              pend_reg;
    logic [7:0]        pend_a_reg, pend_b_reg;
    logic [7:0]        sh_a_reg, sh_b_reg;
    logic              active_reg;
    logic [1:0]        idx_reg;
    logic [DROP_W-1:0] drop_reg;

    logic       pair_done;
    logic       consume;
    logic       byte_done;
    logic       start;
    logic [1:0] next_idx;
    logic [7:0] tx_data;

    assign pair_done = rdy && slot_reg;
    assign consume   = !active_reg && pend_reg;
    assign start     = consume || (byte_done && (idx_reg != LAST_IDX));
    assign next_idx  = consume ? 2'd0 : (idx_reg + 2'd1);

`ifdef IQ_UART_FRAMER_CHECKSUM_EN
    logic [7:0] checksum;
    assign checksum = SYNC_BYTE + sh_a_reg + sh_b_reg;
`endif

    // The sync byte needs no shadow, so the consuming cycle can start it directly.
    always_comb begin
        tx_data = SYNC_BYTE;
        case (next_idx)
            2'd1:    tx_data = sh_a_reg;
            2'd2:    tx_data = sh_b_reg;
`ifdef IQ_UART_FRAMER_CHECKSUM_EN
            2'd3:    tx_data = checksum;
`endif
            default: tx_data = SYNC_BYTE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_reg   <= 1'b0;
            a_reg      <= '0;
            pend_reg   <= 1'b0;
            pend_a_reg <= '0;
            pend_b_reg <= '0;
            sh_a_reg   <= '0;
            sh_b_reg   <= '0;
            active_reg <= 1'b0;
            idx_reg    <= '0;
            drop_reg   <= '0;
        end else begin
            if (rdy) begin
                slot_reg <= ~slot_reg;
                if (!slot_reg)
                    a_reg <= value;
            end

            if (consume) begin
                sh_a_reg   <= pend_a_reg;
                sh_b_reg   <= pend_b_reg;
                active_reg <= 1'b1;
                idx_reg    <= 2'd0;
            end else if (byte_done) begin
                if (idx_reg == LAST_IDX)
                    active_reg <= 1'b0;
                else
                    idx_reg <= idx_reg + 2'd1;
            end

            // A pair arriving on the consuming edge refills the buffer it just vacated.
            if (pair_done && (!pend_reg || consume)) begin
                pend_reg   <= 1'b1;
                pend_a_reg <= a_reg;
                pend_b_reg <= value;
            end else begin
                if (consume)
                    pend_reg <= 1'b0;
                if (pair_done && (drop_reg != {DROP_W{1'b1}}))
                    drop_reg <= drop_reg + {{(DROP_W-1){1'b0}}, 1'b1};
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .data (tx_data),
        .tx   (tx),
        .done (byte_done)
    );

    assign busy     = active_reg;
    assign pend     = pend_reg;
    assign drop_cnt = drop_reg;

endmodule
